// File: rtl/pi_write_fifo_if.sv
// Pi-to-sequencer command queue bus: push side, head-of-queue side and read-return.
interface pi_write_fifo_if;
  logic        push;
  logic [22:0] push_addr;
  logic        push_a0;
  logic        push_sz;
  logic        push_rw;
  logic [15:0] push_data;
  logic        full;
  logic        empty;
  logic        txn_in_progress;
  logic        overflow;
  logic        op_req;
  logic [22:0] op_addr;
  logic        op_a0;
  logic        op_sz;
  logic        op_rw;
  logic [15:0] op_data;
  logic        op_ack;
  logic [15:0] rd_data_in;
  logic [15:0] rd_data;
  logic        rd_valid;

  // Environment side: Pi pushes requests, sequencer acks the head
  modport master (
    output push, push_addr, push_a0, push_sz, push_rw, push_data,
    output op_ack, rd_data_in,
    input  full, empty, txn_in_progress, overflow,
    input  op_req, op_addr, op_a0, op_sz, op_rw, op_data,
    input  rd_data, rd_valid
  );

  // Queue side
  modport slave (
    input  push, push_addr, push_a0, push_sz, push_rw, push_data,
    input  op_ack, rd_data_in,
    output full, empty, txn_in_progress, overflow,
    output op_req, op_addr, op_a0, op_sz, op_rw, op_data,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/pi_write_fifo.sv
// Ordered queue of Pi bus requests feeding the 68K bus-cycle sequencer;
// retires the head on op_ack and holds captured read data for the Pi.
module pi_write_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input logic            c7m,
  input logic            reset,
  pi_write_fifo_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [22:0] addr;
    logic        a0;
    logic        sz;
    logic        rw;
    logic [15:0] data;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            head;
  entry_t            push_entry;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              overflow_q;
  logic              rd_valid_q;
  logic [15:0]       rd_data_q;
  logic              is_full;
  logic              is_empty;
  logic              do_push;
  logic              do_pop;
  logic              drop;

  // Accept/retire decisions; a full queue still accepts when the head retires this cycle
  always_comb begin
    is_full    = (count == CNT_W'(DEPTH));
    is_empty   = (count == CNT_W'(0));
    do_pop     = !reset && bus.op_ack && !is_empty;
    do_push    = !reset && bus.push && (!is_full || do_pop);
    drop       = !reset && bus.push && is_full && !do_pop;
    head       = mem[rd_ptr];
    push_entry = '{addr: bus.push_addr, a0: bus.push_a0, sz: bus.push_sz,
                   rw: bus.push_rw, data: bus.push_data};
  end

  // Entry storage; contents are intentionally left unreset
  always_ff @(posedge c7m) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // Pointers and occupancy
  always_ff @(posedge c7m) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky drop flag and read-return capture; a read retiring wins over a read being queued
  always_ff @(posedge c7m) begin
    if (reset) begin
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 16'h0000;
    end else begin
      if (drop) overflow_q <= 1'b1;
      if (do_pop && head.rw) begin
        rd_data_q  <= bus.rd_data_in;
        rd_valid_q <= 1'b1;
      end else if (do_push && bus.push_rw) begin
        rd_valid_q <= 1'b0;
      end
    end
  end

  assign bus.full            = is_full;
  assign bus.empty           = is_empty;
  assign bus.txn_in_progress = !is_empty;
  assign bus.op_req          = !is_empty;
  assign bus.overflow        = overflow_q;
  assign bus.op_addr         = head.addr;
  assign bus.op_a0           = head.a0;
  assign bus.op_sz           = head.sz;
  assign bus.op_rw           = head.rw;
  assign bus.op_data         = head.data;
  assign bus.rd_data         = rd_data_q;
  assign bus.rd_valid        = rd_valid_q;

endmodule

// File: tb/tb_pi_write_fifo.sv
// Directed bench for pi_write_fifo with DEPTH=4.
module tb_pi_write_fifo;

  logic c7m;
  logic reset;
  int   n_assert;
  int   n_fail;

  logic [22:0] exp_addr [$];
  logic [15:0] exp_data [$];

  pi_write_fifo_if bus ();

  pi_write_fifo #(.DEPTH(4)) dut (
    .c7m   (c7m),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial c7m = 1'b0;
  always #5 c7m = ~c7m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample point is 1 time unit after it; strobes drop afterwards
  task automatic step();
    @(posedge c7m);
    #1;
    bus.push   = 1'b0;
    bus.op_ack = 1'b0;
  endtask

  task automatic set_push(input logic [22:0] addr, input logic a0, input logic sz,
                          input logic rw, input logic [15:0] data);
    bus.push      = 1'b1;
    bus.push_addr = addr;
    bus.push_a0   = a0;
    bus.push_sz   = sz;
    bus.push_rw   = rw;
    bus.push_data = data;
  endtask

  task automatic check_head(input string tag, input logic [22:0] addr,
                            input logic rw, input logic [15:0] data);
    check({tag, ".op_req"},  32'(bus.op_req),  32'd1);
    check({tag, ".op_addr"}, 32'(bus.op_addr), 32'(addr));
    check({tag, ".op_rw"},   32'(bus.op_rw),   32'(rw));
    check({tag, ".op_data"}, 32'(bus.op_data), 32'(data));
  endtask

  initial begin
    n_assert       = 0;
    n_fail         = 0;
    reset          = 1'b1;
    bus.push       = 1'b0;
    bus.push_addr  = '0;
    bus.push_a0    = 1'b0;
    bus.push_sz    = 1'b0;
    bus.push_rw    = 1'b0;
    bus.push_data  = '0;
    bus.op_ack     = 1'b0;
    bus.rd_data_in = '0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst.empty",    32'(bus.empty),           32'd1);
    check("rst.full",     32'(bus.full),            32'd0);
    check("rst.op_req",   32'(bus.op_req),          32'd0);
    check("rst.txn",      32'(bus.txn_in_progress), 32'd0);
    check("rst.overflow", 32'(bus.overflow),        32'd0);
    check("rst.rd_valid", 32'(bus.rd_valid),        32'd0);
    check("rst.rd_data",  32'(bus.rd_data),         32'h0);

    // Single write, one-edge latency, then ack
    set_push(23'h7FF000, 1'b1, 1'b1, 1'b0, 16'hBEEF);
    step();
    check_head("t1.head", 23'h7FF000, 1'b0, 16'hBEEF);
    check("t1.op_a0",  32'(bus.op_a0),           32'd1);
    check("t1.op_sz",  32'(bus.op_sz),           32'd1);
    check("t1.txn",    32'(bus.txn_in_progress), 32'd1);
    check("t1.empty0", 32'(bus.empty),           32'd0);
    bus.op_ack = 1'b1;
    step();
    check("t1.empty", 32'(bus.empty),           32'd1);
    check("t1.txn0",  32'(bus.txn_in_progress), 32'd0);
    check("t1.req0",  32'(bus.op_req),          32'd0);

    // Fill, overflow, drain in order
    for (int i = 0; i < 4; i++) begin
      set_push(23'h000100 + 23'(i), 1'b0, 1'b0, 1'b0, 16'hA000 + 16'(i));
      step();
    end
    check("t2.full",  32'(bus.full),     32'd1);
    check("t2.ovf0",  32'(bus.overflow), 32'd0);
    set_push(23'h0001FF, 1'b0, 1'b0, 1'b0, 16'hDEAD);
    step();
    check("t2.ovf",   32'(bus.overflow), 32'd1);
    check("t2.full2", 32'(bus.full),     32'd1);
    for (int i = 0; i < 4; i++) begin
      check_head($sformatf("t2.drain%0d", i), 23'h000100 + 23'(i), 1'b0, 16'hA000 + 16'(i));
      bus.op_ack = 1'b1;
      step();
    end
    check("t2.empty",  32'(bus.empty),    32'd1);
    check("t2.sticky", 32'(bus.overflow), 32'd1);
    // Ack on empty queue is ignored
    bus.op_ack = 1'b1;
    step();
    check("t2.ack_empty", 32'(bus.empty), 32'd1);
    check("t2.ack_full",  32'(bus.full),  32'd0);

    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t2.ovf_clr", 32'(bus.overflow), 32'd0);

    // Read behind two writes; read data capture and rd_valid clearing
    set_push(23'h000010, 1'b0, 1'b0, 1'b0, 16'h0001);
    step();
    set_push(23'h000011, 1'b0, 1'b0, 1'b0, 16'h0002);
    step();
    set_push(23'h5FF000, 1'b0, 1'b0, 1'b1, 16'h0000);
    step();
    check_head("t3.w0", 23'h000010, 1'b0, 16'h0001);
    bus.op_ack = 1'b1;
    step();
    check_head("t3.w1", 23'h000011, 1'b0, 16'h0002);
    bus.op_ack = 1'b1;
    step();
    check("t3.rdv0", 32'(bus.rd_valid), 32'd0);
    check("t3.rd.addr", 32'(bus.op_addr), 32'h5FF000);
    check("t3.rd.rw",   32'(bus.op_rw),   32'd1);
    bus.op_ack     = 1'b1;
    bus.rd_data_in = 16'h1234;
    step();
    check("t3.rd_data",  32'(bus.rd_data),  32'h1234);
    check("t3.rd_valid", 32'(bus.rd_valid), 32'd1);
    check("t3.empty",    32'(bus.empty),    32'd1);
    set_push(23'h5FF002, 1'b0, 1'b0, 1'b1, 16'h0000);
    step();
    check("t3.rdv_clr",  32'(bus.rd_valid), 32'd0);
    check("t3.rd_hold",  32'(bus.rd_data),  32'h1234);
    bus.op_ack     = 1'b1;
    bus.rd_data_in = 16'h5678;
    step();
    check("t3.rd_data2", 32'(bus.rd_data),  32'h5678);
    check("t3.rd_valid2",32'(bus.rd_valid), 32'd1);

    // Full queue: simultaneous push and ack accepted without overflow
    for (int i = 0; i < 4; i++) begin
      set_push(23'h000300 + 23'(i), 1'b0, 1'b0, 1'b0, 16'hB000 + 16'(i));
      step();
    end
    check("t4.full", 32'(bus.full), 32'd1);
    set_push(23'h000304, 1'b0, 1'b0, 1'b0, 16'hB004);
    bus.op_ack = 1'b1;
    step();
    check("t4.full2", 32'(bus.full),     32'd1);
    check("t4.ovf",   32'(bus.overflow), 32'd0);
    for (int i = 1; i < 5; i++) begin
      check_head($sformatf("t4.drain%0d", i), 23'h000300 + 23'(i), 1'b0, 16'hB000 + 16'(i));
      bus.op_ack = 1'b1;
      step();
    end
    check("t4.empty", 32'(bus.empty), 32'd1);

    // Ten entries with interleaved acks so both pointers wrap twice
    for (int i = 0; i < 10; i++) begin
      if (exp_data.size() >= 2) begin
        check_head($sformatf("t5.mid%0d", i), exp_addr[0], 1'b0, exp_data[0]);
        bus.op_ack = 1'b1;
        void'(exp_addr.pop_front());
        void'(exp_data.pop_front());
      end
      set_push(23'h000400 + 23'(i), 1'b0, 1'b0, 1'b0, 16'hC000 + 16'(i));
      exp_addr.push_back(23'h000400 + 23'(i));
      exp_data.push_back(16'hC000 + 16'(i));
      step();
    end
    for (int k = 0; k < 4 && exp_data.size() > 0; k++) begin
      check_head($sformatf("t5.tail%0d", k), exp_addr[0], 1'b0, exp_data[0]);
      bus.op_ack = 1'b1;
      void'(exp_addr.pop_front());
      void'(exp_data.pop_front());
      step();
    end
    check("t5.empty", 32'(bus.empty),    32'd1);
    check("t5.ovf",   32'(bus.overflow), 32'd0);

    // Reset with entries queued and a concurrent ack/push
    for (int i = 0; i < 3; i++) begin
      set_push(23'h000500 + 23'(i), 1'b0, 1'b0, 1'b0, 16'hD000 + 16'(i));
      step();
    end
    check("t6.pre_req",  32'(bus.op_req),   32'd1);
    check("t6.pre_rdv",  32'(bus.rd_valid), 32'd1);
    reset      = 1'b1;
    bus.op_ack = 1'b1;
    set_push(23'h000600, 1'b0, 1'b0, 1'b1, 16'hEEEE);
    step();
    reset = 1'b0;
    check("t6.empty",    32'(bus.empty),    32'd1);
    check("t6.op_req",   32'(bus.op_req),   32'd0);
    check("t6.overflow", 32'(bus.overflow), 32'd0);
    check("t6.rd_valid", 32'(bus.rd_valid), 32'd0);
    check("t6.rd_data",  32'(bus.rd_data),  32'h0);
    step();
    check("t6.idle_req", 32'(bus.op_req),   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
